// File: rtl/result_drain_ctrl_if.sv
// Command, results-SRAM read port and host stream of the result drain controller.
// The host/bench side uses the master modport; the controller uses the slave modport.
interface result_drain_ctrl_if #(
  parameter int ADDRESSSIZE     = 10,
  parameter int PARTIAL_SUM_BW  = 20,
  parameter int MATRIX_SIZE     = 8,
  parameter int WORDSIZE_Result = PARTIAL_SUM_BW * MATRIX_SIZE
);
  logic                       start;
  logic [ADDRESSSIZE-1:0]     base_addr;
  logic [ADDRESSSIZE:0]       num_rows;
  logic                       busy;
  logic                       done;
  logic                       sram_read_req;
  logic [ADDRESSSIZE-1:0]     sram_address;
  logic [WORDSIZE_Result-1:0] sram_data_in;
  // out_valid/out_ready: a row transfers in any cycle where both are high; once
  // out_valid rises it stays high with out_data/out_last/out_row_idx stable until accepted.
  logic                       out_valid;
  logic                       out_ready;
  logic [WORDSIZE_Result-1:0] out_data;
  logic                       out_last;
  logic [ADDRESSSIZE-1:0]     out_row_idx;
  logic [1:0]                 dbg_state;

  modport master (
    output start, base_addr, num_rows, sram_data_in, out_ready,
    input  busy, done, sram_read_req, sram_address,
    input  out_valid, out_data, out_last, out_row_idx, dbg_state
  );

  modport slave (
    input  start, base_addr, num_rows, sram_data_in, out_ready,
    output busy, done, sram_read_req, sram_address,
    output out_valid, out_data, out_last, out_row_idx, dbg_state
  );
endinterface

// File: rtl/result_drain_ctrl.sv
// Streams a tile of rows from the results SRAM to the host through a 4-entry FWFT FIFO,
// issuing reads only while FIFO occupancy plus the in-flight read leaves room.
module result_drain_ctrl #(
  parameter int ADDRESSSIZE     = 10,
  parameter int PARTIAL_SUM_BW  = 20,
  parameter int MATRIX_SIZE     = 8,
  parameter int WORDSIZE_Result = PARTIAL_SUM_BW * MATRIX_SIZE
) (
  input  logic               clk,
  input  logic               rstn,
  result_drain_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int ENTRY_W = WORDSIZE_Result + ADDRESSSIZE + 1;
  localparam logic [ADDRESSSIZE:0]   ONE_ROW  = (ADDRESSSIZE+1)'(1);
  localparam logic [ADDRESSSIZE-1:0] ADDR_INC = ADDRESSSIZE'(1);

  logic [1:0]             r_state;
  logic [ADDRESSSIZE-1:0] r_next_addr;
  logic [ADDRESSSIZE-1:0] r_addr_q;
  logic [ADDRESSSIZE:0]   r_reads_left;
  logic [ADDRESSSIZE-1:0] r_issue_idx;
  logic                   r_inflight;
  logic [ADDRESSSIZE-1:0] r_inflight_idx;
  logic                   r_inflight_last;
  logic [ENTRY_W-1:0]     r_fifo [4];
  logic [1:0]             r_wptr;
  logic [1:0]             r_rptr;
  logic [2:0]             r_count;

  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;
  logic                   w_last_hs;
  logic [ENTRY_W-1:0]     w_head;

  // Credit: the read issued now lands next cycle, so it must be counted against the FIFO.
  assign w_issue   = (r_state == S_READ) && (r_reads_left != '0) &&
                     (({1'b0, r_count} + {3'b000, r_inflight}) < 4'd4);
  assign w_valid   = (r_count != 3'd0);
  assign w_head    = r_fifo[r_rptr];
  assign w_push    = r_inflight;
  assign w_pop     = w_valid & bus.out_ready;
  assign w_last_hs = w_pop & w_head[ENTRY_W-1];

  assign bus.busy          = (r_state == S_READ) || (r_state == S_DRAIN);
  assign bus.done          = (r_state == S_DONE);
  assign bus.sram_read_req = w_issue;
  assign bus.sram_address  = w_issue ? r_next_addr : r_addr_q;
  assign bus.out_valid     = w_valid;
  assign bus.out_data      = w_valid ? w_head[WORDSIZE_Result-1:0] : '0;
  assign bus.out_row_idx   = w_valid ? w_head[WORDSIZE_Result +: ADDRESSSIZE] : '0;
  assign bus.out_last      = w_valid & w_head[ENTRY_W-1];
  assign bus.dbg_state     = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_next_addr     <= '0;
      r_addr_q        <= '0;
      r_reads_left    <= '0;
      r_issue_idx     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_idx  <= '0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr_q        <= r_next_addr;
        r_next_addr     <= r_next_addr + ADDR_INC;
        r_reads_left    <= r_reads_left - ONE_ROW;
        r_issue_idx     <= r_issue_idx + ADDR_INC;
        r_inflight_idx  <= r_issue_idx;
        r_inflight_last <= (r_reads_left == ONE_ROW);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_next_addr  <= bus.base_addr;
            r_reads_left <= bus.num_rows;
            r_issue_idx  <= '0;
            r_state      <= (bus.num_rows == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (w_last_hs)                                   r_state <= S_DONE;
          else if (w_issue && (r_reads_left == ONE_ROW))   r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_hs) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // Storage needs no reset: entries are only observed while r_count says they are live.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {r_inflight_last, r_inflight_idx, bus.sram_data_in};
  end
endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl: SRAM model, expected-row queue, timing and address checks.
module tb_result_drain_ctrl;
  localparam int AW = 10;
  localparam int DW = 160;
  localparam int EW = DW + AW + 1;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_fail;

  result_drain_ctrl_if bus ();

  result_drain_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int e = 0; e < 8; e++) w[e*20 +: 20] = 20'(a) * 20'h10101 + 20'(e);
    return w;
  endfunction

  // Results SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.sram_read_req) bus.sram_data_in <= word(bus.sram_address);
  end

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur;
  logic [EW-1:0] stall_val;
  logic          stall_q;
  logic [AW-1:0] exp_addr;
  int reads, pops, dones;
  int t_start, first_read_cyc, first_valid_cyc, last_hs_cyc, done_cyc;

  always @(negedge clk) begin
    if (rstn) begin
      cur = {bus.out_last, bus.out_row_idx, bus.out_data};
      if (stall_q) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_hold", cur, stall_val);
      end
      if (bus.sram_read_req) begin
        if (first_read_cyc < 0) first_read_cyc = cyc;
        check("sram_addr", bus.sram_address, exp_addr);
        exp_addr = exp_addr + 1'b1;
        reads++;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check("row_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("row", cur, exp_q.pop_front());
        pops++;
        last_hs_cyc = cyc;
      end
      if (bus.busy) check("outstanding_le4", (reads - pops) <= 4, 1'b1);
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end
      stall_q   = bus.out_valid && !bus.out_ready;
      stall_val = cur;
    end else begin
      stall_q = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic ready_pat(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  task automatic prep_drain(input logic [AW-1:0] base, input int n);
    exp_addr = base;
    reads = 0; pops = 0; dones = 0;
    first_read_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), AW'(i), word(base + AW'(i))});
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.num_rows = 11'(n);
    t_start = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
  endtask

  task automatic run_drain(input logic [AW-1:0] base, input int n, input int mode, input int restart_at);
    prep_drain(base, n);
    bus.out_ready = ready_pat(mode, 0);
    pulse_start(base, n);
    for (int c = 0; c < 300 && dones == 0; c++) begin
      bus.out_ready = ready_pat(mode, c);
      bus.start     = (c == restart_at);
      bus.base_addr = (c == restart_at) ? AW'(500) : AW'(0);
      bus.num_rows  = (c == restart_at) ? 11'd2 : 11'd0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("done_seen", dones, 1);
    check("rows_delivered", pops, n);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("busy_after", bus.busy, 1'b0);
    check("idle_after", bus.dbg_state, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    stall_q = 1'b0; exp_addr = '0;
    reads = 0; pops = 0; dones = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
    bus.out_ready = 1'b0; bus.sram_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {bus.busy, bus.done, bus.sram_read_req, bus.sram_address,
                         bus.out_valid, bus.out_last, bus.out_row_idx, bus.out_data}, '0);
    check("reset_state", bus.dbg_state, 2'd0);
    rstn = 1'b1;

    // 1: basic 4-row drain, host always ready
    run_drain(10'd0, 4, 0, -1);
    check("t1_first_read", first_read_cyc - t_start, 1);
    check("t1_first_valid", first_valid_cyc - t_start, 3);
    check("t1_back_to_back", last_hs_cyc - first_valid_cyc, 3);
    check("t1_done_lat", done_cyc - last_hs_cyc, 1);

    // 2: backpressure pattern 1,0,0,1
    run_drain(10'd64, 8, 1, -1);

    // 3: address wrap 1022 -> 1
    run_drain(10'd1022, 4, 0, -1);
    check("t3_reads", reads, 4);
    check("t3_wrapped_addr", exp_addr, 10'd2);

    // 4: zero rows
    run_drain(10'd5, 0, 0, -1);
    check("t4_no_reads", reads, 0);
    check("t4_done_lat", done_cyc - t_start, 1);
    check("t4_no_valid", first_valid_cyc, -1);

    // 5: second start mid-drain is ignored
    run_drain(10'd40, 8, 0, 2);
    check("t5_reads", reads, 8);

    // 6: reset after two of six rows
    bus.out_ready = 1'b1;
    prep_drain(10'd200, 6);
    pulse_start(10'd200, 6);
    for (int c = 0; c < 100 && pops < 2; c++) begin
      @(negedge clk); #1;
    end
    check("t6_pre_reset_pops", pops, 2);
    rstn = 1'b0;
    #1;
    check("t6_reset_outs", {bus.busy, bus.done, bus.sram_read_req, bus.sram_address,
                            bus.out_valid, bus.out_last, bus.out_row_idx, bus.out_data}, '0);
    check("t6_reset_state", bus.dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rstn = 1'b1;
    run_drain(10'd300, 3, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
